// File: rtl/reg_file_p_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_p_if : write/read/clear bus of the reg_file_p regfile   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface reg_file_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              clear_req;
  logic              busy;
  logic              clear_done;

  modport master (
    output write, write_register, write_data, read_register1, read_register2, clear_req,
    input  read_data1, read_data2, busy, clear_done
  );

  modport slave (
    input  write, write_register, write_data, read_register1, read_register2, clear_req,
    output read_data1, read_data2, busy, clear_done
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_p.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_p : 2R/1W register file with bypass, optional zero reg  |
// | and a sequential one-entry-per-cycle clear engine.  rev 1.0      |
// +------------------------------------------------------------------+
module reg_file_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_p_if.slave  bus
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] counter;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_en = bus.write && (state != CLEAR);
  // Entry 0 never stores user data when it is the hardwired zero register.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (bus.write_register == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.clear_req) begin
        counter <= '0;
      end else if (state == CLEAR) begin
        counter <= counter + 1'b1;
      end
      if (state == CLEAR) begin
        mem[counter] <= '0;
      end else if (wr_ok) begin
        mem[bus.write_register] <= bus.write_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clear_req) state_nxt = CLEAR;
      CLEAR:   if (counter == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = (state == CLEAR);
  assign bus.clear_done = (state == DONE);

  // Bypass is gated by reset so reads stay zero while reset is held.
  always_comb begin
    rd1 = mem[bus.read_register1];
    if (wr_en && !reset && (bus.read_register1 == bus.write_register)) rd1 = bus.write_data;
    if ((ZERO_REG != 0) && (bus.read_register1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem[bus.read_register2];
    if (wr_en && !reset && (bus.read_register2 == bus.write_register)) rd2 = bus.write_data;
    if ((ZERO_REG != 0) && (bus.read_register2 == '0)) rd2 = '0;
  end

  assign bus.read_data1 = rd1;
  assign bus.read_data2 = rd2;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_p.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_file_p : directed vectors and clear/reset sequences       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_reg_file_p;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_file_p_if #(.DATA_W(8),  .ADDR_W(5)) bus_a();
  reg_file_p_if #(.DATA_W(8),  .ADDR_W(5)) bus_b();
  reg_file_p_if #(.DATA_W(16), .ADDR_W(3)) bus_c();

  reg_file_p #(.DATA_W(8), .ADDR_W(5), .ZERO_REG(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  reg_file_p #(.DATA_W(8), .ADDR_W(5), .ZERO_REG(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  reg_file_p #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       w;
    logic [4:0] wr;
    logic [7:0] wd;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[9];

  task automatic drive_a(input logic w, input logic [4:0] wr, input logic [7:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
    bus_a.write          = w;
    bus_a.write_register = wr;
    bus_a.write_data     = wd;
    bus_a.read_register1 = r1;
    bus_a.read_register2 = r2;
  endtask

  initial begin
    int cnt;
    logic seen;

    vecs[0] = '{1'b1, 5'd3,  8'h5A, 5'd3,  5'd4,  8'h5A, 8'h00};
    vecs[1] = '{1'b0, 5'd0,  8'h00, 5'd3,  5'd4,  8'h5A, 8'h00};
    vecs[2] = '{1'b1, 5'd7,  8'hC3, 5'd7,  5'd7,  8'hC3, 8'hC3};
    vecs[3] = '{1'b0, 5'd0,  8'h00, 5'd7,  5'd3,  8'hC3, 8'h5A};
    vecs[4] = '{1'b1, 5'd0,  8'hFF, 5'd0,  5'd0,  8'h00, 8'h00};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 5'd0,  5'd7,  8'h00, 8'hC3};
    vecs[6] = '{1'b1, 5'd3,  8'h11, 5'd3,  5'd7,  8'h11, 8'hC3};
    vecs[7] = '{1'b1, 5'd31, 8'hEE, 5'd30, 5'd31, 8'h00, 8'hEE};
    vecs[8] = '{1'b0, 5'd0,  8'h00, 5'd31, 5'd3,  8'hEE, 8'h11};

    drive_a(1'b0, '0, '0, '0, '0);
    bus_a.clear_req = 1'b0;
    bus_b.write = 1'b0; bus_b.write_register = '0; bus_b.write_data = '0;
    bus_b.read_register1 = '0; bus_b.read_register2 = '0; bus_b.clear_req = 1'b0;
    bus_c.write = 1'b0; bus_c.write_register = '0; bus_c.write_data = '0;
    bus_c.read_register1 = '0; bus_c.read_register2 = '0; bus_c.clear_req = 1'b0;

    #1 reset = 1'b1;
    // Write and clear attempted under reset must not take effect.
    drive_a(1'b1, 5'd3, 8'h77, 5'd3, 5'd3);
    bus_a.clear_req = 1'b1;
    @(negedge clk);
    #1;
    check("reset_busy", 32'(bus_a.busy), 0);
    check("reset_done", 32'(bus_a.clear_done), 0);
    check("reset_rd1", 32'(bus_a.read_data1), 0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, '0, '0, 5'd3, 5'd3);
    bus_a.clear_req = 1'b0;
    #1;
    check("post_reset_rd", 32'(bus_a.read_data1), 0);
    check("post_reset_busy", 32'(bus_a.busy), 0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_a(vecs[i].w, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      #1;
      check($sformatf("vec%0d_rd1", i), 32'(bus_a.read_data1), 32'(vecs[i].e1));
      check($sformatf("vec%0d_rd2", i), 32'(bus_a.read_data2), 32'(vecs[i].e2));
    end

    // Ordinary entry 0 when the zero register is disabled.
    @(negedge clk);
    drive_a(1'b0, '0, '0, '0, '0);
    bus_b.write = 1'b1; bus_b.write_register = 5'd0; bus_b.write_data = 8'hFF;
    bus_b.read_register1 = 5'd0;
    #1 check("zr0_bypass", 32'(bus_b.read_data1), 32'hFF);
    @(negedge clk);
    bus_b.write = 1'b0;
    #1 check("zr0_stored", 32'(bus_b.read_data1), 32'hFF);

    // Narrow/wide instance round trip.
    @(negedge clk);
    bus_c.write = 1'b1; bus_c.write_register = 3'd7; bus_c.write_data = 16'hBEEF;
    @(negedge clk);
    bus_c.write = 1'b0; bus_c.read_register1 = 3'd7;
    #1 check("c_roundtrip", 32'(bus_c.read_data1), 32'hBEEF);

    // Fill A with 0xA5, then clear.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drive_a(1'b1, 5'(a), 8'hA5, '0, '0);
    end
    @(negedge clk);
    drive_a(1'b0, '0, '0, 5'd9, 5'd9);
    bus_a.clear_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) bus_a.clear_req = 1'b0;
      #1;
      if (!bus_a.busy) break;
      cnt++;
      if (i == 0) begin
        drive_a(1'b1, 5'd9, 8'h77, 5'd9, 5'd9);
        #1 check("busy_no_bypass", 32'(bus_a.read_data1), 32'hA5);
      end else if (i == 1) begin
        drive_a(1'b0, '0, '0, 5'd9, 5'd9);
      end
    end
    check("clear_busy_cycles", 32'(cnt), 32);
    check("clear_done_pulse", 32'(bus_a.clear_done), 1);
    @(negedge clk);
    #1 check("clear_done_width", 32'(bus_a.clear_done), 0);
    check("busy_write_dropped", 32'(bus_a.read_data1), 0);
    cnt = 0;
    for (int a = 0; a < 32; a++) begin
      bus_a.read_register1 = 5'(a);
      #1;
      if (bus_a.read_data1 !== 8'h00) cnt++;
    end
    check("cleared_entries_nonzero", 32'(cnt), 0);

    // clear_req held through DONE restarts after one IDLE cycle.
    @(negedge clk);
    bus_c.clear_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (!bus_c.busy) break;
      cnt++;
    end
    check("c_clear_cycles", 32'(cnt), 8);
    check("c_done", 32'(bus_c.clear_done), 1);
    @(negedge clk);
    #1 check("c_idle_gap", 32'(bus_c.busy), 0);
    @(negedge clk);
    #1 check("c_restart", 32'(bus_c.busy), 1);
    bus_c.clear_req = 1'b0;
    bus_c.read_register1 = 3'd7;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (bus_c.clear_done) seen = 1'b1;
      if (!bus_c.busy && seen) break;
    end
    check("c_cleared_entry", 32'(bus_c.read_data1), 0);

    // Reset mid-clear.
    @(negedge clk);
    drive_a(1'b1, 5'd20, 8'h44, '0, '0);
    @(negedge clk);
    drive_a(1'b0, '0, '0, 5'd20, 5'd20);
    #1 check("pre_abort_rd", 32'(bus_a.read_data1), 32'h44);
    bus_a.clear_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_a.clear_req = 1'b0;
    end
    #1 check("mid_clear_busy", 32'(bus_a.busy), 1);
    check("mid_clear_uncleared", 32'(bus_a.read_data1), 32'h44);
    #1 reset = 1'b1;
    drive_a(1'b1, 5'd20, 8'h99, 5'd20, 5'd0);
    #1;
    check("abort_busy", 32'(bus_a.busy), 0);
    check("abort_rd1", 32'(bus_a.read_data1), 0);
    check("abort_done", 32'(bus_a.clear_done), 0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, '0, '0, 5'd20, 5'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus_a.clear_done || bus_a.busy) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 0);
    check("abort_entry_cleared", 32'(bus_a.read_data1), 0);
    @(negedge clk);
    drive_a(1'b1, 5'd2, 8'h12, 5'd0, 5'd0);
    @(negedge clk);
    drive_a(1'b0, '0, '0, 5'd2, 5'd2);
    #1 check("post_abort_write", 32'(bus_a.read_data2), 32'h12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero, 0 = entry 0 ordinary.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 write  input  1  write enable.
REQ-007 write_register  input  ADDR_W  write address.
REQ-008 write_data  input  DATA_W  write data.
REQ-009 read_register1, read_register2  input  ADDR_W each  read addresses, ports 1/2.
REQ-010 read_data1, read_data2  output  DATA_W each  read data, ports 1/2.
REQ-011 clear_req  input  1  request sequential clear of all entries.
REQ-012 busy  output  1  clear sequence in progress.
REQ-013 clear_done  output  1  one-cycle pulse, clear sequence finished.

Function
REQ-014 Write: on rising clk with write=1 and busy=0, entry[write_register] <= write_data; write ignored when busy=1.
REQ-015 Reads combinational, zero latency: read_dataN = entry[read_registerN].
REQ-016 Bypass: when write=1, busy=0, write_register == read_registerN, read_dataN = write_data in the same cycle, both ports independently.
REQ-017 ZERO_REG=1: writes to address 0 discarded; read of address 0 returns 0, bypass suppressed for address 0.
REQ-018 ZERO_REG=0: entry 0 behaves as every other entry.
REQ-019 FSM states IDLE, CLEAR, DONE; encoding free.
REQ-020 IDLE: clear_req=1 at rising edge -> CLEAR, clear counter <= 0; else stay IDLE.
REQ-021 CLEAR: each cycle entry[counter] <= 0, counter <= counter+1; on cycle with counter = DEPTH-1 -> DONE; exactly DEPTH cycles in CLEAR.
REQ-022 DONE: one cycle, then -> IDLE unconditionally.
REQ-023 busy = 1 iff state CLEAR; clear_done = 1 iff state DONE; both registered-state decodes, no combinational path from inputs.
REQ-024 clear_req ignored in CLEAR and DONE; clear_req held high through DONE starts new sequence on first IDLE cycle.
REQ-025 Reads during CLEAR return array contents (already-cleared entries read 0, others old values); no bypass while busy=1.
REQ-026 Writes in DONE cycle accepted normally (busy=0).
REQ-027 Counter width ADDR_W; no wrap beyond DEPTH-1 within one sequence.

Reset
REQ-028 reset=1 asynchronously forces every entry to 0, state IDLE, counter 0, busy 0, clear_done 0, independent of clk.
REQ-029 reset asserted mid-CLEAR aborts sequence immediately; no clear_done pulse generated for aborted sequence.
REQ-030 While reset=1, write and clear_req have no effect; read_dataN = 0 for all addresses.
REQ-031 First rising edge after reset deassertion processes write/clear_req normally.

Verification
REQ-032 Defaults: reset; write 0x5A to addr 3, next cycle read_register1=3 -> read_data1=0x5A; read_register2=4 -> 0x00.
REQ-033 Bypass: write=1, write_register=7, write_data=0xC3, read_register1=read_register2=7 same cycle -> both read 0xC3 before edge.
REQ-034 Zero reg: ZERO_REG=1, write 0xFF to addr 0 -> read 0x00 same cycle and after; ZERO_REG=0 instance -> read 0xFF.
REQ-035 Clear: fill all 32 entries with 0xA5, pulse clear_req 1 cycle -> busy high exactly 32 cycles, clear_done high 1 cycle after, all entries read 0x00; write during busy to addr 9 discarded (addr 9 reads 0x00).
REQ-036 Reset mid-clear: start clear, assert reset after 10 CLEAR cycles between edges -> busy=0, all reads 0x00 immediately, no clear_done pulse afterwards.
REQ-037 Parameter sweep: DATA_W=16, ADDR_W=3 -> clear lasts 8 cycles; write/read 0xBEEF at addr 7 round-trips.
